// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial, multi-cycle subtractor: diff = data_A - data_B - borrow_in,
// modulo 2^WIDTH. One bit per clock, LSB first, through a single borrow
// flip-flop. A start/busy/done handshake connects it to the controller.
//
// Timing: start is accepted in IDLE on edge E0. SHIFT edges E1..E_WIDTH each
// process one bit. E_WIDTH loads the result and raises done for one cycle
// (the DONE state). The next edge returns to IDLE, so a held start gives one
// operation every WIDTH+2 cycles.
//
// Configuration macro:
//   SUB_OVF_EN  when defined, adds the signed-overflow output and the two
//               flops that keep the captured operand MSBs.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous active-high reset
//   start       in   1      request; sampled only in IDLE
//   data_A      in   WIDTH  minuend, captured on accepted start
//   data_B      in   WIDTH  subtrahend, captured on accepted start
//   borrow_in   in   1      initial borrow, captured on accepted start
//   busy        out  1      high while state != IDLE
//   done        out  1      one-cycle result-valid pulse
//   diff        out  WIDTH  difference, held until the next completion/reset
//   borrow_out  out  1      final unsigned borrow (A < B + borrow_in)
//   overflow    out  1      signed overflow (SUB_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_A,
  input  logic [WIDTH-1:0] data_B,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_borrow;
  // Holds the WIDTH-1 result bits produced so far; the last bit is merged in
  // combinationally on the completion edge, so no spare bit is carried.
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
  logic             r_busy;
  logic             r_done;
`ifdef SUB_OVF_EN
  // Shift registers lose the MSBs long before completion, so keep them here.
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_overflow;
`endif

  // Current bit-slice: full subtractor on the LSBs of the shift registers.
  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_c_next;
  logic [WIDTH-1:0] w_full;
  logic             w_last;

  assign w_a      = r_a_sh[0];
  assign w_b      = r_b_sh[0];
  assign w_d      = w_a ^ w_b ^ r_borrow;
  assign w_c_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
  // New bit enters at the MSB; on the final edge this is the whole result.
  assign w_full   = {w_d, r_res};
  assign w_last   = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, so an aborted operation
      // leaves no stale operand or partial result behind.
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_borrow     <= 1'b0;
      r_res        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef SUB_OVF_EN
      r_a_msb      <= 1'b0;
      r_b_msb      <= 1'b0;
      r_overflow   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout: every right-hand side reads
      // the pre-edge value, which is what makes the shift chains work.
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh   <= data_A;
            r_b_sh   <= data_B;
            r_borrow <= borrow_in;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SHIFT;
`ifdef SUB_OVF_EN
            r_a_msb  <= data_A[WIDTH-1];
            r_b_msb  <= data_B[WIDTH-1];
`endif
          end
        end

        S_SHIFT: begin
          r_res    <= w_full[WIDTH-1:1];
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_borrow <= w_c_next;
          if (w_last) begin
            // Completion edge: publish result; counter never wraps.
            r_diff       <= w_full;
            r_borrow_out <= w_c_next;
            r_done       <= 1'b1;
            r_state      <= S_DONE;
`ifdef SUB_OVF_EN
            r_overflow   <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;
`ifdef SUB_OVF_EN
  assign overflow   = r_overflow;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Scoreboard bench for serial_subtractor (WIDTH=8). Each accepted operation
// pushes its expected result and capture cycle; a negedge monitor pops an
// entry on every done pulse and compares result, borrow, overflow (when
// SUB_OVF_EN is defined) and latency.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_A     (a_in),
    .data_B     (b_in),
    .borrow_in  (bin),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (bout)
`ifdef SUB_OVF_EN
    ,
    .overflow   (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           cap;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int           total     = 0;
  int           bad       = 0;
  int           cyc       = 0;
  logic         prev_done = 1'b0;
  logic [W-1:0] last_diff = '0;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction, independent of the bit-serial form.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bi, input int cap);
    exp_t r;
    int   t;
    t     = int'(a) - int'(b) - int'(bi);
    r.d   = t[W-1:0];
    r.bo  = (t < 0);
    r.ov  = (a[W-1] ^ b[W-1]) & (a[W-1] ^ r.d[W-1]);
    r.cap = cap;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && done) begin
      check("done_one_cycle", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("diff", {24'd0, diff}, {24'd0, e.d});
        check("borrow_out", {31'd0, bout}, {31'd0, e.bo});
        check("latency", cyc - e.cap, W);
`ifdef SUB_OVF_EN
        check("overflow", {31'd0, ovf}, {31'd0, e.ov});
`endif
        last_diff = e.d;
      end
    end
    prev_done = done;
  end

  // One accepted start; returns on the negedge right after the capture edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    bin   = bi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sb.push_back(model(a, b, bi, cyc));
    check("busy_after_capture", {31'd0, busy}, 32'd1);
  endtask

  // Wait (bounded) for all outstanding results, then let DONE fall to IDLE.
  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    bin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
`ifdef SUB_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst = 1'b0;

    // Directed operations, including borrow and signed-overflow boundaries.
    launch(8'h5A, 8'h3C, 1'b0); drain();
    launch(8'h00, 8'h01, 1'b0); drain();
    launch(8'h10, 8'h10, 1'b1); drain();
    launch(8'hFF, 8'h00, 1'b1); drain();
    launch(8'h80, 8'h01, 1'b0); drain();
    launch(8'h7F, 8'hFF, 1'b0); drain();
    launch(8'h00, 8'hFF, 1'b1); drain();

    // A few random operands.
    for (int i = 0; i < 6; i++) begin
      launch(W'($urandom_range(255)), W'($urandom_range(255)),
             1'($urandom_range(1)));
      drain();
    end

    // Start during SHIFT is ignored; diff must not show partial results.
    launch(8'h33, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    a_in  = 8'hAA;
    b_in  = 8'h01;
    bin   = 1'b1;
    start = 1'b1;
    check("diff_held_mid_shift", {24'd0, diff}, {24'd0, last_diff});
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (12) @(negedge clk);

    // Start held high: captures every W+2 cycles.
    @(negedge clk);
    a_in  = 8'h44;
    b_in  = 8'h45;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    c0 = cyc;
    sb.push_back(model(8'h44, 8'h45, 1'b0, c0));
    sb.push_back(model(8'hC8, 8'h37, 1'b1, c0 + W + 2));
    sb.push_back(model(8'h01, 8'h80, 1'b0, c0 + 2 * (W + 2)));
    a_in = 8'hC8;
    b_in = 8'h37;
    bin  = 1'b1;
    repeat (W + 2) @(negedge clk);
    a_in = 8'h01;
    b_in = 8'h80;
    bin  = 1'b0;
    repeat (W + 2) @(negedge clk);
    start = 1'b0;
    drain();

    // Reset in the middle of SHIFT aborts the operation.
    launch(8'hC3, 8'h5A, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_diff", {24'd0, diff}, 32'd0);
    check("midrst_bout", {31'd0, bout}, 32'd0);
    rst = 1'b0;
    last_diff = '0;
    repeat (14) @(negedge clk);
    check("midrst_no_done_busy", {31'd0, busy}, 32'd0);
    launch(8'h9D, 8'h2E, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
